// File: rtl/color_remap_pkg.sv
// Select-code offsets (relative to the channel count) and the identity-config builder for the colour remapper.
package color_remap_pkg;

    localparam int SEL_ZERO  = 0;
    localparam int SEL_ONES  = 1;
    localparam int SEL_INV   = 2;
    localparam int MAX_CFG_W = 256;

    // Channel k selects k; channel 0 occupies the most significant code slice.
    function automatic logic [MAX_CFG_W-1:0] identity_cfg(input int n_ch, input int sel_w);
        logic [MAX_CFG_W-1:0] r;
        r = '0;
        for (int k = 0; k < n_ch; k++) begin
            for (int b = 0; b < sel_w; b++) begin
                r[(n_ch-1-k)*sel_w + b] = k[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/color_remap_pipe_if.sv
// Pixel stream interface: input beat and output beat, each with valid/ready.
interface color_remap_pipe_if #(
    parameter int CH_W = 8,
    parameter int N_CH = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_CH*CH_W-1:0] in_pixel;
    logic                 in_sof;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_CH*CH_W-1:0] out_pixel;
    logic                 out_sof;

    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, out_pixel, out_sof
    );

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, out_pixel, out_sof
    );
endinterface

// File: rtl/color_remap_pipe_channel_sel.sv
// Combinational source mux for one output channel; no latency, no flow control.
// The own-channel inversion code is only built when COLOR_REMAP_INVERT_EN is defined.
module channel_sel
    import color_remap_pkg::*;
#(
    parameter int CH_W  = 8,
    parameter int N_CH  = 3,
    parameter int SEL_W = 4,
    parameter int K     = 0
) (
    input  logic [SEL_W-1:0]     sel,
    input  logic [N_CH*CH_W-1:0] pixel,
    output logic [CH_W-1:0]      ch
);

    localparam int CODE_ZERO = N_CH + SEL_ZERO;
    localparam int CODE_ONES = N_CH + SEL_ONES;
    localparam int CODE_INV  = N_CH + SEL_INV;

    always_comb begin
        ch = '0;
        if (int'(sel) < N_CH) begin
            ch = pixel[(N_CH-1-int'(sel))*CH_W +: CH_W];
        end else if (int'(sel) == CODE_ZERO) begin
            ch = '0;
        end else if (int'(sel) == CODE_ONES) begin
            ch = '1;
        end else if (int'(sel) == CODE_INV) begin
`ifdef COLOR_REMAP_INVERT_EN
            ch = ~pixel[(N_CH-1-K)*CH_W +: CH_W];
`else
            ch = '0;
`endif
        end
    end

endmodule

// File: rtl/color_remap_pipe.sv
// Per-channel colour remap, one-cycle registered, in_ready = !out_valid || out_ready; config switches only on sof.
// Optional own-channel inversion code via COLOR_REMAP_INVERT_EN.
module color_remap_pipe
    import color_remap_pkg::*;
#(
    parameter int CH_W  = 8,
    parameter int N_CH  = 3,
    parameter int SEL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*SEL_W-1:0] cfg_sel,
    input  logic                  cfg_load,
    output logic                  cfg_pending,
    color_remap_pipe_if.slave     px
);

    localparam int CFG_W = N_CH * SEL_W;
    localparam int PIX_W = N_CH * CH_W;
    localparam logic [MAX_CFG_W-1:0] ID_FULL = identity_cfg(N_CH, SEL_W);
    localparam logic [CFG_W-1:0]     ID_CFG  = ID_FULL[CFG_W-1:0];

    logic [CFG_W-1:0] active_cfg;
    logic [CFG_W-1:0] pend_cfg;
    logic [CFG_W-1:0] use_cfg;
    logic [PIX_W-1:0] mapped;
    logic             accept;
    logic             sof_acc;

    assign px.in_ready = !px.out_valid || px.out_ready;
    assign accept      = px.in_valid && px.in_ready;
    assign sof_acc     = accept && px.in_sof;

    // A same-cycle load beats the pending register so the sof beat sees the freshest codes.
    always_comb begin
        use_cfg = active_cfg;
        if (sof_acc) begin
            if (cfg_load) begin
                use_cfg = cfg_sel;
            end else if (cfg_pending) begin
                use_cfg = pend_cfg;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        channel_sel #(
            .CH_W  (CH_W),
            .N_CH  (N_CH),
            .SEL_W (SEL_W),
            .K     (k)
        ) u_sel (
            .sel   (use_cfg[(N_CH-1-k)*SEL_W +: SEL_W]),
            .pixel (px.in_pixel),
            .ch    (mapped[(N_CH-1-k)*CH_W +: CH_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_cfg  <= ID_CFG;
            pend_cfg    <= ID_CFG;
            cfg_pending <= 1'b0;
        end else begin
            if (cfg_load) begin
                pend_cfg <= cfg_sel;
            end
            if (sof_acc) begin
                active_cfg  <= use_cfg;
                cfg_pending <= 1'b0;
            end else if (cfg_load) begin
                cfg_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px.out_valid <= 1'b0;
            px.out_pixel <= '0;
            px.out_sof   <= 1'b0;
        end else if (accept) begin
            px.out_valid <= 1'b1;
            px.out_pixel <= mapped;
            px.out_sof   <= px.in_sof;
        end else if (px.out_ready) begin
            px.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_color_remap_pipe.sv
// Directed-vector bench for color_remap_pipe (RGB888, 4-bit select codes).
module tb_color_remap_pipe;

    logic        clk;
    logic        rst;
    logic [11:0] cfg_sel;
    logic        cfg_load;
    logic        cfg_pending;
    int          checks;
    int          errors;

    color_remap_pipe_if #(.CH_W(8), .N_CH(3)) px ();

    color_remap_pipe #(.CH_W(8), .N_CH(3), .SEL_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_sel     (cfg_sel),
        .cfg_load    (cfg_load),
        .cfg_pending (cfg_pending),
        .px          (px.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [23:0] p, input logic s);
        px.in_valid = v;
        px.in_pixel = p;
        px.in_sof   = s;
    endtask

    initial begin
        logic [23:0] inv_exp;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cfg_sel = 12'h000;
        cfg_load = 1'b0;
        drive(1'b0, 24'h0, 1'b0);
        px.out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", {31'd0, px.out_valid}, 32'd0);
        chk("rst_out_pixel", {8'd0, px.out_pixel}, 32'd0);
        chk("rst_out_sof", {31'd0, px.out_sof}, 32'd0);
        chk("rst_cfg_pending", {31'd0, cfg_pending}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, px.in_ready}, 32'd1);

        // Identity after reset
        drive(1'b1, 24'h123456, 1'b1);
        step();
        chk("ident_valid", {31'd0, px.out_valid}, 32'd1);
        chk("ident_pixel", {8'd0, px.out_pixel}, 32'h123456);
        chk("ident_sof", {31'd0, px.out_sof}, 32'd1);

        // Mid-frame load waits for sof
        cfg_sel = 12'h210;
        cfg_load = 1'b1;
        drive(1'b1, 24'h112233, 1'b0);
        step();
        cfg_load = 1'b0;
        chk("midframe_pixel", {8'd0, px.out_pixel}, 32'h112233);
        chk("midframe_sof", {31'd0, px.out_sof}, 32'd0);
        chk("midframe_pending", {31'd0, cfg_pending}, 32'd1);
        drive(1'b1, 24'h112233, 1'b1);
        step();
        chk("swap_pixel", {8'd0, px.out_pixel}, 32'h332211);
        chk("swap_pending", {31'd0, cfg_pending}, 32'd0);

        // Two loads with no beats: last one wins; idle output drains
        drive(1'b0, 24'h0, 1'b0);
        cfg_sel = 12'h000;
        cfg_load = 1'b1;
        step();
        cfg_sel = 12'h345;
        step();
        cfg_load = 1'b0;
        chk("drain_valid", {31'd0, px.out_valid}, 32'd0);
        chk("two_loads_pending", {31'd0, cfg_pending}, 32'd1);
        drive(1'b1, 24'h0F00A0, 1'b1);
        step();
`ifdef COLOR_REMAP_INVERT_EN
        inv_exp = 24'h00FF5F;
`else
        inv_exp = 24'h00FF00;
`endif
        chk("zero_ones_inv", {8'd0, px.out_pixel}, {8'd0, inv_exp});
        chk("zero_ones_inv_pending", {31'd0, cfg_pending}, 32'd0);

        // Load coinciding with sof beat
        cfg_sel = 12'h111;
        cfg_load = 1'b1;
        drive(1'b1, 24'hAABBCC, 1'b1);
        step();
        cfg_load = 1'b0;
        chk("coincide_pixel", {8'd0, px.out_pixel}, 32'hBBBBBB);
        chk("coincide_pending", {31'd0, cfg_pending}, 32'd0);

        // Out-of-range code yields zero
        cfg_sel = 12'hF02;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        chk("bad_code_pixel", {8'd0, px.out_pixel}, 32'h00AACC);

        // Back to identity, then stall for 4 cycles
        cfg_sel = 12'h012;
        cfg_load = 1'b1;
        drive(1'b1, 24'h010101, 1'b1);
        step();
        cfg_load = 1'b0;
        chk("pre_stall_pixel", {8'd0, px.out_pixel}, 32'h010101);
        px.out_ready = 1'b0;
        drive(1'b1, 24'h0A0A0A, 1'b0);
        #1;
        chk("stall_in_ready_c0", {31'd0, px.in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", {31'd0, px.out_valid}, 32'd1);
            chk("stall_pixel", {8'd0, px.out_pixel}, 32'h010101);
            chk("stall_sof", {31'd0, px.out_sof}, 32'd1);
            chk("stall_in_ready", {31'd0, px.in_ready}, 32'd0);
        end
        px.out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, px.in_ready}, 32'd1);
        step();
        drive(1'b0, 24'h0, 1'b0);
        chk("release_pixel", {8'd0, px.out_pixel}, 32'h0A0A0A);
        chk("release_sof", {31'd0, px.out_sof}, 32'd0);
        chk("release_valid", {31'd0, px.out_valid}, 32'd1);
        step();
        chk("release_no_dup", {31'd0, px.out_valid}, 32'd0);

        // Reset with output held and a load pending
        cfg_sel = 12'h210;
        cfg_load = 1'b1;
        drive(1'b1, 24'h123456, 1'b1);
        step();
        chk("pre_rst_pixel", {8'd0, px.out_pixel}, 32'h563412);
        cfg_sel = 12'h111;
        drive(1'b0, 24'h0, 1'b0);
        px.out_ready = 1'b0;
        step();
        cfg_load = 1'b0;
        chk("pre_rst_pending", {31'd0, cfg_pending}, 32'd1);
        chk("pre_rst_valid", {31'd0, px.out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, px.out_valid}, 32'd0);
        chk("rst_async_pixel", {8'd0, px.out_pixel}, 32'd0);
        chk("rst_async_pending", {31'd0, cfg_pending}, 32'd0);
        step();
        rst = 1'b0;
        px.out_ready = 1'b1;
        drive(1'b1, 24'h123456, 1'b1);
        step();
        drive(1'b0, 24'h0, 1'b0);
        chk("rst_identity_pixel", {8'd0, px.out_pixel}, 32'h123456);
        chk("rst_identity_valid", {31'd0, px.out_valid}, 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_remap_pipe.md
COLOR_REMAP_PIPE -- requirements
Module: color_remap_pipe

Interface
REQ-001 Parameter CH_W, default 8, bits per colour channel.
REQ-002 Parameter N_CH, default 3, channel count; channel 0 is the most significant slice of a pixel (R in RGB888).
REQ-003 Parameter SEL_W, default 4, select-code width per output channel; SHALL be at least clog2(N_CH+3).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_sel  input  N_CH*SEL_W  select code per output channel; channel k code at the same slice position as channel k.
REQ-007 cfg_load  input  1  one-cycle strobe that captures cfg_sel into the pending register.
REQ-008 cfg_pending  output  1  high while a loaded config awaits frame start.
REQ-009 in_valid / in_ready  input / output  1 each  input beat handshake.
REQ-010 in_pixel  input  N_CH*CH_W  input pixel.
REQ-011 in_sof  input  1  marks the first pixel of a frame.
REQ-012 out_valid / out_ready  output / input  1 each  output beat handshake.
REQ-013 out_pixel  output  N_CH*CH_W  remapped pixel.
REQ-014 out_sof  output  1  in_sof delayed alongside its pixel.

Function
REQ-015 Output channel k, with active code s: s<N_CH gives input channel s; s=N_CH gives 0; s=N_CH+1 gives all-ones; s=N_CH+2 gives the bitwise inverse of input channel k (see REQ-027); any other code gives 0.
REQ-016 A beat transfers when valid and ready are both high in the same cycle.
REQ-017 Latency SHALL be exactly one cycle: an accepted input appears on out_* on the following cycle.
REQ-018 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-019 While out_valid=1 and out_ready=0, out_pixel, out_sof and out_valid SHALL hold stable.
REQ-020 out_valid SHALL fall after an output transfer with no simultaneous input transfer.
REQ-021 cfg_load SHALL write the pending register and set cfg_pending; a later cfg_load before sof overwrites it, last one wins.
REQ-022 An accepted beat with in_sof=1 and cfg_pending=1 SHALL copy pending to active and clear cfg_pending; that beat already uses the new configuration.
REQ-023 If cfg_load coincides with an accepted sof beat, the cfg_sel value present that cycle SHALL go directly to active, that beat uses it, and cfg_pending ends low.
REQ-024 The active configuration SHALL never change on non-sof beats, so a frame is never split between two configurations.

Reset
REQ-025 On rst: active config = identity (channel k selects k), pending = identity, cfg_pending=0, out_valid=0, out_pixel=0, out_sof=0; any in-flight beat is discarded.
REQ-026 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 Macro COLOR_REMAP_INVERT_EN: when defined, code N_CH+2 gives the inverted own channel; when undefined, code N_CH+2 gives 0 and no inversion logic is built.

Structure
REQ-028 Package color_remap_pkg SHALL hold the select-code constants as offsets from N_CH (SEL_ZERO, SEL_ONES, SEL_INV) and the identity-config function.
REQ-029 A combinational sub-module channel_sel SHALL implement REQ-015 for one channel and be instantiated N_CH times.

Verification
REQ-030 After reset with no cfg_load, in_pixel=0x123456 -> out_pixel=0x123456 one cycle later.
REQ-031 cfg_load with codes {2,1,0} mid-frame, then in_pixel=0x112233 without sof -> 0x112233; next beat with in_sof=1 and in_pixel=0x112233 -> 0x332211, cfg_pending drops.
REQ-032 Codes {3,4,5} with the macro defined, in_pixel=0x0F00A0 -> 0x00FF5F; with the macro undefined -> 0x00FF00.
REQ-033 out_ready held low for 4 cycles with in_valid=1 -> out_pixel stable, in_ready=0, no beat lost or duplicated after release.
REQ-034 cfg_load coinciding with an accepted sof beat, codes {1,1,1}, in_pixel=0xAABBCC -> 0xBBBBBB, cfg_pending=0.
REQ-035 rst asserted while out_valid=1 -> out_valid=0 immediately and the configuration returns to identity.
